uart_in_arbiter: RTL and testbench

Shares the single UART→USB FIFO among `UART_COUNT` UART receivers. Each receiver presents one received byte; the arbiter grants one receiver at a time and writes an (index, value) byte pair into the FIFO. This is the exact inverse of the USB→UART demux framing, so the host decodes both directions identically. It sits between the UART receiver bank and the USB-side TX FIFO.

---
 rtl/uart_mux_pkg.sv | 22 ++
 rtl/uart_in_arbiter_if.sv | 23 ++
 rtl/uart_rr_arbiter.sv | 62 ++++++
 rtl/uart_in_arbiter.sv | 107 ++++++++++
 tb/tb_uart_in_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mux_pkg.sv
// Shared definitions for the UART<->USB mux/demux path: state encoding, default byte width,
// and the grant-index width helper.
package uart_mux_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WRITE_INDEX = 2'd1;
  localparam logic [1:0] WRITE_DATA  = 2'd2;

  typedef enum logic [1:0] {
    StIdle       = IDLE,
    StWriteIndex = WRITE_INDEX,
    StWriteData  = WRITE_DATA
  } arb_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_in_arbiter_if.sv
// Bundle between the UART receiver bank / TX FIFO and uart_in_arbiter.
// master: the arbiter side; slave: receivers plus FIFO.
interface uart_in_arbiter_if #(
  parameter int unsigned DATA_BITS  = uart_mux_pkg::DEFAULT_DATA_BITS,
  parameter int unsigned UART_COUNT = 1
);
  logic [UART_COUNT-1:0]           rx_ready;
  logic [UART_COUNT*DATA_BITS-1:0] rx_data;
  logic [UART_COUNT-1:0]           rx_ack;
  logic                            fifo_full;
  logic                            fifo_write;
  logic [DATA_BITS-1:0]            fifo_data;

  modport master (
    input  rx_ready, rx_data, fifo_full,
    output rx_ack, fifo_write, fifo_data
  );

  modport slave (
    output rx_ready, rx_data, fifo_full,
    input  rx_ack, fifo_write, fifo_data
  );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational one-hot grant plus binary index over the receiver requests.
// With UART_IN_ARB_ROUND_ROBIN_EN the search starts at a rotating pointer; otherwise lowest wins.
module uart_rr_arbiter
  import uart_mux_pkg::*;
#(
  parameter int unsigned UART_COUNT = 1,
  parameter int unsigned IDX_W      = idx_width(UART_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [UART_COUNT-1:0] req,
  input  logic                  take,
  output logic [UART_COUNT-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  valid
);

  logic [IDX_W-1:0] ptr;

`ifdef UART_IN_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer moves one past the channel just granted, wrapping at UART_COUNT.
  always_comb begin
    ptr_d = ptr_q;
    if (take && valid) begin
      ptr_d = (int'(grant_idx) == int'(UART_COUNT) - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, take};
  assign ptr = '0;
`endif

  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < UART_COUNT; off++) begin
      cand = (int'(ptr) + off) % UART_COUNT;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_in_arbiter.sv
// Shares the UART->USB TX FIFO among UART_COUNT receivers, writing (index, byte) pairs.
// Define UART_IN_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module uart_in_arbiter
  import uart_mux_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned UART_COUNT = 1
) (
  input logic              clk,
  input logic              reset,
  uart_in_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_width(UART_COUNT);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  byte_q, byte_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [DATA_BITS-1:0]  idx_ext;
  logic [UART_COUNT-1:0] ack_q, ack_d;
  logic                  write_q, write_d;

  logic [UART_COUNT-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  valid;
  logic                  take;

  uart_rr_arbiter #(
    .UART_COUNT (UART_COUNT),
    .IDX_W      (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.rx_ready),
    .take      (take),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (valid)
  );

  always_comb begin
    idx_ext              = '0;
    idx_ext[IDX_W-1:0]   = idx_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    data_d  = data_q;
    ack_d   = '0;
    write_d = 1'b0;
    take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          take    = 1'b1;
          idx_d   = grant_idx;
          byte_d  = bus.rx_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
          ack_d   = grant;
          state_d = StWriteIndex;
        end
      end
      StWriteIndex: begin
        if (!bus.fifo_full) begin
          write_d = 1'b1;
          data_d  = idx_ext;
          state_d = StWriteData;
        end
      end
      StWriteData: begin
        // Skipping the cycle right after a write lets fifo_full catch up with that write.
        if (!write_q && !bus.fifo_full) begin
          write_d = 1'b1;
          data_d  = byte_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      write_q <= write_d;
    end
  end

  assign bus.rx_ack     = ack_q;
  assign bus.fifo_write = write_q;
  assign bus.fifo_data  = data_q;

endmodule

// File: tb/tb_uart_in_arbiter.sv
// Directed bench for uart_in_arbiter: a 4-channel instance for framing, arbitration, stalls
// and reset, and a 1-channel instance streaming 100 random bytes against a random fifo_full.
module tb_uart_in_arbiter;
  import uart_mux_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_in_arbiter_if #(.DATA_BITS(8), .UART_COUNT(4)) if4 ();
  uart_in_arbiter_if #(.DATA_BITS(8), .UART_COUNT(1)) if1 ();

  uart_in_arbiter #(.DATA_BITS(8), .UART_COUNT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.master)
  );

  uart_in_arbiter #(.DATA_BITS(8), .UART_COUNT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wr4_q[$];
  logic [7:0] wr1_q[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         consec   = 0;
  logic       prev4    = 1'b0;
  logic       prev1    = 1'b0;
  logic       rand_en  = 1'b0;

  always @(posedge clk) cyc++;

  // FIFO-side monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (if4.fifo_write) wr4_q.push_back('{data: if4.fifo_data, cyc: cyc});
    if (if1.fifo_write) wr1_q.push_back(if1.fifo_data);
    if (if4.fifo_write && prev4) consec++;
    if (if1.fifo_write && prev1) consec++;
    prev4 = if4.fifo_write;
    prev1 = if1.fifo_write;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if1.fifo_full = rand_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_byte4(input int ch, input logic [7:0] b);
    if4.rx_data[ch*8 +: 8] = b;
  endtask

  int         base;
  int         exp_ch[5];
  logic [7:0] bytes[100];
  logic       got_ack;

  initial begin
    if4.rx_ready  = '0;
    if4.rx_data   = '0;
    if4.fifo_full = 1'b0;
    if1.rx_ready  = '0;
    if1.rx_data   = '0;

    // Reset state.
    reset = 1'b1;
    repeat (2) tick();
    check_eq("rst_ack", 32'(if4.rx_ack), 32'h0);
    check_eq("rst_write", 32'(if4.fifo_write), 32'h0);
    check_eq("rst_data", 32'(if4.fifo_data), 32'h0);
    reset = 1'b0;
    tick();

    // Single request on channel 2: ack at 1, index at 2, data at 4.
    if4.rx_ready = 4'b0100;
    set_byte4(2, 8'hA5);
    tick();
    check_eq("t1_ack", 32'(if4.rx_ack), 32'h4);
    check_eq("t1_nowrite_c1", 32'(if4.fifo_write), 32'h0);
    if4.rx_ready = 4'b0000;
    tick();
    check_eq("t1_write_c2", 32'(if4.fifo_write), 32'h1);
    check_eq("t1_index", 32'(if4.fifo_data), 32'h02);
    check_eq("t1_ack_pulse", 32'(if4.rx_ack), 32'h0);
    tick();
    check_eq("t1_nowrite_c3", 32'(if4.fifo_write), 32'h0);
    tick();
    check_eq("t1_write_c4", 32'(if4.fifo_write), 32'h1);
    check_eq("t1_data", 32'(if4.fifo_data), 32'hA5);
    repeat (4) tick();

    // All channels ready continuously; reset first so the priority pointer starts at 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr4_q.delete();
    for (int i = 0; i < 4; i++) set_byte4(i, 8'h10 + 8'(i));
    if4.rx_ready = 4'b1111;
`ifdef UART_IN_ARB_ROUND_ROBIN_EN
    exp_ch = '{0, 1, 2, 3, 0};
`else
    exp_ch = '{0, 0, 0, 0, 0};
`endif
    repeat (22) tick();
    if4.rx_ready = 4'b0000;
    repeat (8) tick();
    check_eq("t2_count_ge10", 32'(wr4_q.size() >= 10), 32'h1);
    if (wr4_q.size() >= 10) begin
      for (int k = 0; k < 5; k++) begin
        check_eq($sformatf("t2_idx%0d", k), 32'(wr4_q[2*k].data), 32'(exp_ch[k]));
        check_eq($sformatf("t2_dat%0d", k), 32'(wr4_q[2*k+1].data), 32'h10 + 32'(exp_ch[k]));
      end
    end

    // Channel 1 with fifo_full high for five cycles from entry to the index state.
    wr4_q.delete();
    base = cyc;
    if4.rx_ready = 4'b0010;
    set_byte4(1, 8'h5C);
    tick();
    check_eq("t3_ack", 32'(if4.rx_ack), 32'h2);
    if4.rx_ready  = 4'b0000;
    if4.fifo_full = 1'b1;
    repeat (5) tick();
    if4.fifo_full = 1'b0;
    repeat (6) tick();
    check_eq("t3_count", 32'(wr4_q.size()), 32'd2);
    if (wr4_q.size() == 2) begin
      check_eq("t3_idx_cyc", 32'(wr4_q[0].cyc - base), 32'd7);
      check_eq("t3_idx", 32'(wr4_q[0].data), 32'h01);
      check_eq("t3_dat_cyc", 32'(wr4_q[1].cyc - base), 32'd9);
      check_eq("t3_dat", 32'(wr4_q[1].data), 32'h5C);
    end

    // Byte is latched at grant; a later change on rx_data must not leak in.
    wr4_q.delete();
    if4.rx_ready = 4'b0001;
    set_byte4(0, 8'h3C);
    tick();
    if4.rx_ready = 4'b0000;
    set_byte4(0, 8'hC3);
    repeat (6) tick();
    check_eq("t4_count", 32'(wr4_q.size()), 32'd2);
    if (wr4_q.size() == 2) begin
      check_eq("t4_idx", 32'(wr4_q[0].data), 32'h00);
      check_eq("t4_dat", 32'(wr4_q[1].data), 32'h3C);
    end

    // Reset while in the data-write state, then a fresh request on channel 3.
    if4.rx_ready = 4'b1000;
    set_byte4(3, 8'h77);
    tick();
    if4.rx_ready = 4'b0000;
    tick();
    check_eq("t5_idx_write", 32'(if4.fifo_write), 32'h1);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_ack", 32'(if4.rx_ack), 32'h0);
    check_eq("t5_rst_write", 32'(if4.fifo_write), 32'h0);
    check_eq("t5_rst_data", 32'(if4.fifo_data), 32'h0);
    reset = 1'b0;
    wr4_q.delete();
    base = cyc;
    if4.rx_ready = 4'b1000;
    set_byte4(3, 8'h88);
    tick();
    check_eq("t5_ack", 32'(if4.rx_ack), 32'h8);
    if4.rx_ready = 4'b0000;
    repeat (7) tick();
    check_eq("t5_count", 32'(wr4_q.size()), 32'd2);
    if (wr4_q.size() == 2) begin
      check_eq("t5_idx_cyc", 32'(wr4_q[0].cyc - base), 32'd2);
      check_eq("t5_idx", 32'(wr4_q[0].data), 32'h03);
      check_eq("t5_dat_cyc", 32'(wr4_q[1].cyc - base), 32'd4);
      check_eq("t5_dat", 32'(wr4_q[1].data), 32'h88);
    end

    // Single channel: 100 random bytes against a random fifo_full.
    for (int i = 0; i < 100; i++) bytes[i] = 8'($urandom_range(0, 255));
    wr1_q.delete();
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if1.rx_data  = bytes[i];
      if1.rx_ready = 1'b1;
      got_ack      = 1'b0;
      for (int t = 0; t < 100 && !got_ack; t++) begin
        tick();
        if (if1.rx_ack[0]) got_ack = 1'b1;
      end
      if (!got_ack) begin
        check_eq("t6_ack_timeout", 32'h0, 32'h1);
        break;
      end
    end
    if1.rx_ready = 1'b0;
    for (int t = 0; t < 400 && wr1_q.size() < 200; t++) tick();
    rand_en = 1'b0;
    repeat (8) tick();
    check_eq("t6_count", 32'(wr1_q.size()), 32'd200);
    if (wr1_q.size() == 200) begin
      for (int i = 0; i < 100; i++) begin
        check_eq($sformatf("t6_idx%0d", i), 32'(wr1_q[2*i]), 32'h00);
        check_eq($sformatf("t6_dat%0d", i), 32'(wr1_q[2*i+1]), 32'(bytes[i]));
      end
    end
    check_eq("no_back_to_back", 32'(consec), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
